// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// FSM state encoding and next-PC select encoding.
package if_stage_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Control inputs, instruction-memory port and IF/ID outputs of the fetch stage.
// The fetch stage itself connects through the slave modport.
interface if_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  stall_IF_i;
    logic                  stall_IF_ID_i;
    logic                  flush_IF_ID_i;
    logic                  Jump_i;
    logic [ADDR_WIDTH-1:0] jumpAddr_i;
    logic                  branch_taken_i;
    logic [ADDR_WIDTH-1:0] branch_target_i;
    logic                  Stop_i;
    logic [ADDR_WIDTH-1:0] im_addr_o;
    logic [DATA_WIDTH-1:0] im_rdata_i;
    logic [ADDR_WIDTH-1:0] PCD_o;
    logic [DATA_WIDTH-1:0] instrD_o;
    logic                  halted_o;

    modport master (
        output stall_IF_i, stall_IF_ID_i, flush_IF_ID_i, Jump_i, jumpAddr_i,
               branch_taken_i, branch_target_i, Stop_i, im_rdata_i,
        input  im_addr_o, PCD_o, instrD_o, halted_o
    );

    modport slave (
        input  stall_IF_i, stall_IF_ID_i, flush_IF_ID_i, Jump_i, jumpAddr_i,
               branch_taken_i, branch_target_i, Stop_i, im_rdata_i,
        output im_addr_o, PCD_o, instrD_o, halted_o
    );

endinterface

// File: rtl/if_stage_pc_sel.sv
// Combinational next-PC mux. The branch wins over everything because it is
// the oldest instruction in flight; HALT freezes the PC.
module if_stage_pc_sel
    import if_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_halted,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_stall,
    input  logic                  i_stop,
    input  logic                  i_jump,
    input  logic [ADDR_WIDTH-1:0] i_jump_addr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [ADDR_WIDTH-1:0] o_next_pc
);

    pc_sel_e w_sel;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_halted)            w_sel = SEL_HOLD;
        else if (i_branch_taken) w_sel = SEL_BRANCH;
        else if (i_stall)        w_sel = SEL_HOLD;
        else if (i_stop)         w_sel = SEL_HOLD;
        else if (i_jump)         w_sel = SEL_JUMP;
    end

    always_comb begin
        o_next_pc = i_pc;
        case (w_sel)
            SEL_SEQ:    o_next_pc = i_pc + ADDR_WIDTH'(1);
            SEL_JUMP:   o_next_pc = i_jump_addr;
            SEL_BRANCH: o_next_pc = i_branch_target;
            SEL_HOLD:   o_next_pc = i_pc;
            default:    o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and
// RUN/HALT state machine. Memory read is combinational on the current PC.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = if_stage_pkg::NOP_INSTR
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pcd;
    logic [DATA_WIDTH-1:0] r_instr;
    state_e                r_state;

    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [ADDR_WIDTH-1:0] w_pcd_nxt;
    logic [DATA_WIDTH-1:0] w_instr_nxt;
    state_e                w_state_nxt;

    if_stage_pc_sel #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc_sel (
        .i_halted        (r_state == HALT),
        .i_branch_taken  (bus.branch_taken_i),
        .i_branch_target (bus.branch_target_i),
        .i_stall         (bus.stall_IF_i),
        .i_stop          (bus.Stop_i),
        .i_jump          (bus.Jump_i),
        .i_jump_addr     (bus.jumpAddr_i),
        .i_pc            (r_pc),
        .o_next_pc       (w_next_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pcd_nxt   = r_pcd;
        w_instr_nxt = r_instr;
        case (r_state)
            RUN: begin
                if (bus.branch_taken_i) begin
                    w_pcd_nxt   = '0;
                    w_instr_nxt = NOP_INSTR;
                end else if (bus.stall_IF_ID_i) begin
                    w_pcd_nxt   = r_pcd;
                    w_instr_nxt = r_instr;
                end else if (bus.flush_IF_ID_i || bus.Jump_i || bus.Stop_i) begin
                    w_pcd_nxt   = '0;
                    w_instr_nxt = NOP_INSTR;
                end else begin
                    w_pcd_nxt   = r_pc;
                    w_instr_nxt = bus.im_rdata_i;
                end
                // A stalled Stop is not accepted; it is re-evaluated next cycle.
                if (!bus.branch_taken_i && !bus.stall_IF_i && bus.Stop_i)
                    w_state_nxt = HALT;
            end
            HALT: begin
                w_pcd_nxt   = '0;
                w_instr_nxt = NOP_INSTR;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_pcd   <= '0;
            r_instr <= NOP_INSTR;
            r_state <= RUN;
        end else begin
            r_pc    <= w_next_pc;
            r_pcd   <= w_pcd_nxt;
            r_instr <= w_instr_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign bus.im_addr_o = r_pc;
    assign bus.PCD_o     = r_pcd;
    assign bus.instrD_o  = r_instr;
    assign bus.halted_o  = (r_state == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver pushes reference-model results,
// a separate monitor pops and compares them after each clock edge.
module tb_if_stage;

    localparam logic [15:0] NOP = 16'h0000;

    typedef struct {
        bit       rst;
        bit       stall_if;
        bit       stall_ifid;
        bit       flush;
        bit       jump;
        bit [7:0] jaddr;
        bit       br;
        bit [7:0] btgt;
        bit       stop;
    } stim_t;

    typedef struct {
        int          due;
        logic [7:0]  pc;
        logic [7:0]  pcd;
        logic [15:0] instr;
        logic        halted;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] mem [256];
    exp_t        exp_q[$];

    // Reference model state
    int       m_pc;
    int       m_pcd;
    int       m_instr;
    bit       m_halt;

    if_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    if_stage #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.im_rdata_i = mem[bus.im_addr_o];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // One clock of stimulus: drive, advance the model, queue what the DUT must show next edge.
    task automatic step(input stim_t s);
        exp_t e;
        int   cur_pc;
        int   fetched;
        @(posedge clk);
        #1;
        rst                 = s.rst;
        bus.stall_IF_i      = s.stall_if;
        bus.stall_IF_ID_i   = s.stall_ifid;
        bus.flush_IF_ID_i   = s.flush;
        bus.Jump_i          = s.jump;
        bus.jumpAddr_i      = s.jaddr;
        bus.branch_taken_i  = s.br;
        bus.branch_target_i = s.btgt;
        bus.Stop_i          = s.stop;

        if (s.rst) begin
            m_pc = 0; m_pcd = 0; m_instr = NOP; m_halt = 0;
        end else if (m_halt) begin
            m_pcd = 0; m_instr = NOP;
        end else begin
            cur_pc  = m_pc;
            fetched = 32'(mem[m_pc]);
            if (s.br)            m_pc = s.btgt;
            else if (s.stall_if) m_pc = m_pc;
            else if (s.stop)     m_halt = 1;
            else if (s.jump)     m_pc = s.jaddr;
            else                 m_pc = (m_pc + 1) % 256;

            if (s.br) begin
                m_pcd = 0; m_instr = NOP;
            end else if (s.stall_ifid) begin
                m_pcd = m_pcd;
            end else if (s.flush || s.jump || s.stop) begin
                m_pcd = 0; m_instr = NOP;
            end else begin
                m_pcd = cur_pc; m_instr = fetched;
            end
        end

        e.due    = cyc + 1;
        e.pc     = 8'(m_pc);
        e.pcd    = 8'(m_pcd);
        e.instr  = 16'(m_instr);
        e.halted = m_halt;
        exp_q.push_back(e);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(idle());
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        step(s);
        step(s);
    endtask

    // Monitor: compares every queued expectation once its edge has passed.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("im_addr", 32'(bus.im_addr_o), 32'(e.pc));
                check("PCD",     32'(bus.PCD_o),     32'(e.pcd));
                check("instrD",  32'(bus.instrD_o),  32'(e.instr));
                check("halted",  32'(bus.halted_o),  32'(e.halted));
            end
        end
    end

    initial begin : driver
        stim_t s;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        bus.stall_IF_i = 0; bus.stall_IF_ID_i = 0; bus.flush_IF_ID_i = 0;
        bus.Jump_i = 0; bus.jumpAddr_i = 0; bus.branch_taken_i = 0;
        bus.branch_target_i = 0; bus.Stop_i = 0;

        // Sequential fetch through the 0xFF -> 0x00 wrap
        do_reset();
        run_idle(262);

        // Jump at PC=5, then branch beating jump and both stalls
        do_reset();
        run_idle(5);
        s = idle(); s.jump = 1; s.jaddr = 8'h40; step(s);
        run_idle(2);
        s = idle(); s.br = 1; s.btgt = 8'h20; s.jump = 1; s.jaddr = 8'h40;
        s.stall_if = 1; s.stall_ifid = 1; step(s);
        run_idle(2);

        // Stall at PC=7 for 3 cycles, release, then a lone flush
        do_reset();
        run_idle(7);
        s = idle(); s.stall_if = 1; s.stall_ifid = 1;
        repeat (3) step(s);
        run_idle(2);
        s = idle(); s.flush = 1; step(s);
        run_idle(1);

        // Halt at PC=9; other inputs must be ignored until reset
        do_reset();
        run_idle(9);
        s = idle(); s.stop = 1; step(s);
        s = idle(); s.jump = 1; s.jaddr = 8'h55; step(s);
        s = idle(); s.br = 1; s.btgt = 8'h66; step(s);
        s = idle(); s.stall_if = 1; s.stall_ifid = 1; s.flush = 1; step(s);
        run_idle(1);
        do_reset();
        run_idle(2);

        // Stop squashed by a simultaneous branch; stop held off by a stall
        s = idle(); s.stop = 1; s.br = 1; s.btgt = 8'h30; step(s);
        run_idle(2);
        s = idle(); s.stop = 1; s.stall_if = 1; step(s);
        run_idle(2);

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst        = ($urandom_range(0, 199) == 0);
            s.stall_if   = ($urandom_range(0, 99) < 10);
            s.stall_ifid = ($urandom_range(0, 99) < 10);
            s.flush      = ($urandom_range(0, 99) < 8);
            s.jump       = ($urandom_range(0, 99) < 8);
            s.jaddr      = 8'($urandom_range(0, 255));
            s.br         = ($urandom_range(0, 99) < 6);
            s.btgt       = 8'($urandom_range(0, 255));
            s.stop       = ($urandom_range(0, 99) < 2);
            step(s);
        end

        repeat (3) @(posedge clk);
        #5;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
